// File: rtl/genius_pkg.sv
// Shared definitions for the sequence checker: key/round widths, the
// default inactivity limit and the checker state encoding.
package genius_pkg;

   localparam int KEY_W   = 4;
   localparam int ROUND_W = 4;

   // Inactivity limit per press, in clk cycles (used by the timeout option).
   localparam int DEFAULT_TIMEOUT_CYCLES = 50000000;

   typedef enum logic [1:0] {
      ST_IDLE         = 2'd0,
      ST_WAIT_RELEASE = 2'd1,
      ST_WAIT_PRESS   = 2'd2,
      ST_FAIL         = 2'd3
   } state_t;

endpackage

// File: rtl/press_detect.sv
// Press qualification for the sequence checker. Purely combinational:
// tells the FSM whether the buttons are all released, whether something
// is pressed, and whether that press is exactly the expected colour.
// A multi-hot key is a press but never a correct one.
import genius_pkg::*;

module press_detect (
   input  logic [KEY_W-1:0] key,
   input  logic [KEY_W-1:0] seq_data,
   output logic             released,
   output logic             press,
   output logic             correct
);

   logic one_hot;

   // Classify the current key value against the expected colour.
   always_comb begin
      released = (key == '0);
      press    = !released;
      one_hot  = press && ((key & (key - KEY_W'(1))) == '0);
      correct  = one_hot && (key == seq_data);
   end

endmodule

// File: rtl/sequence_checker.sv
// Sequence checker: walks the player's presses through steps 0..round of
// the stored sequence, pulsing match per correct press and round_ok when
// the round completes; any wrong press parks the FSM in FAIL until start.
// Optional feature: define CHECKER_TIMEOUT_EN to fail a round after
// TIMEOUT_CYCLES cycles without a press; otherwise timeout is tied to 0.
//
// Handshake: start is a level sampled every cycle and only acted on in
// IDLE or FAIL (never while busy). A press is any nonzero key seen in
// WAIT_PRESS; every press must be followed by all-released before the
// next one counts. match/round_ok/fail appear one cycle after the press.
import genius_pkg::*;

module sequence_checker #(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic               clk,
   input  logic               R,
   input  logic               start,
   input  logic [ROUND_W-1:0] round,
   input  logic [KEY_W-1:0]   key,
   input  logic [KEY_W-1:0]   seq_data,
   output logic [ROUND_W-1:0] seq_addr,
   output logic               match,
   output logic               round_ok,
   output logic               fail,
   output logic               timeout,
   output logic               busy,
   output state_t             state_dbg
);

   state_t             state_q, state_d;
   logic [ROUND_W-1:0] idx_q, idx_d;
   logic [ROUND_W-1:0] rnd_q, rnd_d;
   logic               match_q, match_d;
   logic               round_ok_q, round_ok_d;
   logic               fail_q, fail_d;
   logic               released, press, correct;
   logic               expired;

   press_detect u_press_detect (
      .key      (key),
      .seq_data (seq_data),
      .released (released),
      .press    (press),
      .correct  (correct)
   );

`ifdef CHECKER_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CNT_W-1:0] cnt_q;
   logic             timeout_q, timeout_d;

   assign expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
   assign timeout = timeout_q;

   // Inactivity counter: restarts on entry to WAIT_PRESS, counts idle cycles.
   always_ff @(posedge clk) begin
      if (!R) begin
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= timeout_d;
         if (state_q == ST_WAIT_RELEASE && released) begin
            cnt_q <= '0;
         end else if (state_q == ST_WAIT_PRESS && !press) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end
`else
   logic unused_cfg;

   assign expired    = 1'b0;
   assign timeout    = 1'b0;
   assign unused_cfg = (TIMEOUT_CYCLES > 0);
`endif

   // State, step index, latched round and registered result flags.
   always_ff @(posedge clk) begin
      if (!R) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         rnd_q      <= '0;
         match_q    <= 1'b0;
         round_ok_q <= 1'b0;
         fail_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         rnd_q      <= rnd_d;
         match_q    <= match_d;
         round_ok_q <= round_ok_d;
         fail_q     <= fail_d;
      end
   end

   // Next-state and result decode for one press at a time.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      rnd_d      = rnd_q;
      match_d    = 1'b0;
      round_ok_d = 1'b0;
      fail_d     = fail_q;
`ifdef CHECKER_TIMEOUT_EN
      timeout_d  = timeout_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               idx_d   = '0;
               rnd_d   = round;
               state_d = ST_WAIT_RELEASE;
            end
         end
         ST_WAIT_RELEASE: begin
            if (released) begin
               state_d = ST_WAIT_PRESS;
            end
         end
         ST_WAIT_PRESS: begin
            if (press) begin
               if (correct) begin
                  match_d = 1'b1;
                  if (idx_q == rnd_q) begin
                     round_ok_d = 1'b1;
                     state_d    = ST_IDLE;
                  end else begin
                     idx_d   = idx_q + ROUND_W'(1);
                     state_d = ST_WAIT_RELEASE;
                  end
               end else begin
                  fail_d  = 1'b1;
                  state_d = ST_FAIL;
               end
            end else if (expired) begin
               fail_d  = 1'b1;
`ifdef CHECKER_TIMEOUT_EN
               timeout_d = 1'b1;
`endif
               state_d = ST_FAIL;
            end
         end
         ST_FAIL: begin
            if (start) begin
               fail_d  = 1'b0;
`ifdef CHECKER_TIMEOUT_EN
               timeout_d = 1'b0;
`endif
               idx_d   = '0;
               rnd_d   = round;
               state_d = ST_WAIT_RELEASE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign seq_addr  = idx_q;
   assign match     = match_q;
   assign round_ok  = round_ok_q;
   assign fail      = fail_q;
   assign busy      = (state_q == ST_WAIT_RELEASE) || (state_q == ST_WAIT_PRESS);
   assign state_dbg = state_q;

endmodule

// File: tb/tb_sequence_checker.sv
// Directed bench for sequence_checker. Inputs change on the falling edge,
// outputs are checked on the following falling edge, so each tick is one
// DUT clock with results already registered.
import genius_pkg::*;

module tb_sequence_checker;

   logic               clk = 1'b0;
   logic               R;
   logic               start;
   logic [ROUND_W-1:0] round;
   logic [KEY_W-1:0]   key;
   logic [KEY_W-1:0]   seq_data;
   logic [ROUND_W-1:0] seq_addr;
   logic               match;
   logic               round_ok;
   logic               fail;
   logic               timeout;
   logic               busy;
   state_t             state_dbg;

   logic [KEY_W-1:0]   seq_mem [16];

   int errors = 0;
   int checks = 0;

   // Clock.
   always #5 clk = ~clk;

   // Sequence memory: combinational read at seq_addr.
   assign seq_data = seq_mem[seq_addr];

   sequence_checker #(.TIMEOUT_CYCLES(10)) dut (
      .clk       (clk),
      .R         (R),
      .start     (start),
      .round     (round),
      .key       (key),
      .seq_data  (seq_data),
      .seq_addr  (seq_addr),
      .match     (match),
      .round_ok  (round_ok),
      .fail      (fail),
      .timeout   (timeout),
      .busy      (busy),
      .state_dbg (state_dbg)
   );

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      R = 1'b0; start = 1'b0; key = '0; round = '0;
      tick(); tick();
      R = 1'b1;
   endtask

   task automatic do_start(input logic [ROUND_W-1:0] r);
      round = r; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // One release cycle followed by one press cycle; key stays held.
   task automatic press(input logic [KEY_W-1:0] k);
      key = '0;
      tick();
      key = k;
      tick();
   endtask

   task automatic fill_pattern();
      for (int i = 0; i < 16; i++) seq_mem[i] = KEY_W'(1) << (i % 4);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      R = 1'b0; start = 1'b1; key = 4'b0001; round = 4'd7;
      tick(); tick();
      checks++; if (seq_addr !== 4'd0) begin errors++; $display("FAIL reset_seq_addr: got %0d expected 0", seq_addr); end
      checks++; if ({match, round_ok, fail, timeout, busy} !== 5'b0) begin errors++;
         $display("FAIL reset_outputs: got %b expected 00000", {match, round_ok, fail, timeout, busy}); end
      start = 1'b0; key = '0;
      R = 1'b1;
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
   endtask

   task automatic test_round_ok();
      do_reset();
      seq_mem[0] = 4'b0001; seq_mem[1] = 4'b0100; seq_mem[2] = 4'b1000;
      do_start(4'd2);
      round = 4'd0;  // must be ignored until the next start
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ok_busy_after_start: got %b expected 1", busy); end
      press(4'b0001);
      checks++; if ({match, round_ok, seq_addr} !== {1'b1, 1'b0, 4'd1}) begin errors++;
         $display("FAIL ok_step0: got m=%b ok=%b addr=%0d expected m=1 ok=0 addr=1", match, round_ok, seq_addr); end
      press(4'b0100);
      checks++; if ({match, round_ok, seq_addr} !== {1'b1, 1'b0, 4'd2}) begin errors++;
         $display("FAIL ok_step1: got m=%b ok=%b addr=%0d expected m=1 ok=0 addr=2", match, round_ok, seq_addr); end
      press(4'b1000);
      checks++; if ({match, round_ok, fail, busy} !== 4'b1100) begin errors++;
         $display("FAIL ok_step2: got m=%b ok=%b fail=%b busy=%b expected 1 1 0 0", match, round_ok, fail, busy); end
      key = '0;
      tick();
      checks++; if ({match, round_ok} !== 2'b00) begin errors++;
         $display("FAIL ok_pulse_width: got m=%b ok=%b expected 0 0", match, round_ok); end
   endtask

   task automatic test_wrong_press();
      do_reset();
      seq_mem[0] = 4'b0001; seq_mem[1] = 4'b0100;
      do_start(4'd1);
      press(4'b0001);
      checks++; if (match !== 1'b1) begin errors++; $display("FAIL wrong_first_match: got %b expected 1", match); end
      press(4'b0010);
      checks++; if ({fail, busy, match, round_ok} !== 4'b1000) begin errors++;
         $display("FAIL wrong_press: got fail=%b busy=%b m=%b ok=%b expected 1 0 0 0", fail, busy, match, round_ok); end
      key = '0;
      tick();
      checks++; if (fail !== 1'b1) begin errors++; $display("FAIL wrong_sticky: got %b expected 1", fail); end
      do_start(4'd1);
      checks++; if ({fail, seq_addr, busy} !== {1'b0, 4'd0, 1'b1}) begin errors++;
         $display("FAIL wrong_restart: got fail=%b addr=%0d busy=%b expected 0 0 1", fail, seq_addr, busy); end
   endtask

   task automatic test_multihot_and_hold();
      int n_match;
      do_reset();
      seq_mem[0] = 4'b0001; seq_mem[1] = 4'b0001; seq_mem[2] = 4'b0010;
      do_start(4'd2);
      press(4'b0101);
      checks++; if ({fail, match} !== 2'b10) begin errors++;
         $display("FAIL multihot: got fail=%b m=%b expected 1 0", fail, match); end
      do_start(4'd2);
      press(4'b0001);
      checks++; if ({match, seq_addr} !== {1'b1, 4'd1}) begin errors++;
         $display("FAIL hold_first: got m=%b addr=%0d expected 1 1", match, seq_addr); end
      n_match = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (match === 1'b1) n_match++;
      end
      checks++; if ({n_match, seq_addr} !== {32'd0, 4'd1}) begin errors++;
         $display("FAIL hold_no_repeat: got matches=%0d addr=%0d expected 0 1", n_match, seq_addr); end
      press(4'b0001);
      checks++; if ({match, seq_addr} !== {1'b1, 4'd2}) begin errors++;
         $display("FAIL hold_after_release: got m=%b addr=%0d expected 1 2", match, seq_addr); end
   endtask

   task automatic test_busy_start_and_reset();
      do_reset();
      fill_pattern();
      do_start(4'd5);
      for (int i = 0; i < 3; i++) press(seq_mem[i]);
      key = '0; round = 4'd0; start = 1'b1;
      tick();
      start = 1'b0;
      checks++; if ({seq_addr, busy, fail} !== {4'd3, 1'b1, 1'b0}) begin errors++;
         $display("FAIL start_while_busy: got addr=%0d busy=%b fail=%b expected 3 1 0", seq_addr, busy, fail); end
      key = seq_mem[3]; R = 1'b0;
      tick();
      R = 1'b1; key = '0;
      checks++; if ({seq_addr, match, round_ok, fail, timeout, busy} !== 9'b0) begin errors++;
         $display("FAIL reset_mid_round: got addr=%0d m=%b ok=%b fail=%b to=%b busy=%b expected all 0",
                  seq_addr, match, round_ok, fail, timeout, busy); end
   endtask

   task automatic test_start_with_key();
      int n_match;
      do_reset();
      seq_mem[0] = 4'b0001;
      key = 4'b0001;
      do_start(4'd0);
      n_match = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (match === 1'b1) n_match++;
      end
      checks++; if ({n_match, busy} !== {32'd0, 1'b1}) begin errors++;
         $display("FAIL start_key_same_cycle: got matches=%0d busy=%b expected 0 1", n_match, busy); end
      press(4'b0001);
      checks++; if ({match, round_ok} !== 2'b11) begin errors++;
         $display("FAIL start_key_then_press: got m=%b ok=%b expected 1 1", match, round_ok); end
   endtask

   task automatic test_timeout();
      do_reset();
      do_start(4'd0);
      tick();  // key released: WAIT_PRESS entered on this edge
`ifdef CHECKER_TIMEOUT_EN
      repeat (9) tick();
      checks++; if (fail !== 1'b0) begin errors++; $display("FAIL timeout_early: got fail=%b expected 0", fail); end
      tick();
      checks++; if ({fail, timeout, busy} !== 3'b110) begin errors++;
         $display("FAIL timeout_fire: got fail=%b to=%b busy=%b expected 1 1 0", fail, timeout, busy); end
      do_start(4'd0);
      checks++; if ({fail, timeout} !== 2'b00) begin errors++;
         $display("FAIL timeout_clear: got fail=%b to=%b expected 0 0", fail, timeout); end
`else
      repeat (1000) tick();
      checks++; if ({fail, timeout, busy} !== 3'b001) begin errors++;
         $display("FAIL no_timeout: got fail=%b to=%b busy=%b expected 0 0 1", fail, timeout, busy); end
`endif
   endtask

   task automatic test_round15();
      int n_match, n_ok;
      logic [ROUND_W-1:0] exp_addr;
      do_reset();
      fill_pattern();
      do_start(4'd15);
      n_match = 0; n_ok = 0;
      for (int i = 0; i < 16; i++) begin
         press(seq_mem[i]);
         if (match === 1'b1) n_match++;
         if (round_ok === 1'b1) n_ok++;
         exp_addr = (i < 15) ? ROUND_W'(i + 1) : 4'd15;
         checks++; if (seq_addr !== exp_addr) begin errors++;
            $display("FAIL r15_addr step %0d: got %0d expected %0d", i, seq_addr, exp_addr); end
      end
      checks++; if ({n_match, n_ok, busy} !== {32'd16, 32'd1, 1'b0}) begin errors++;
         $display("FAIL r15_totals: got matches=%0d oks=%0d busy=%b expected 16 1 0", n_match, n_ok, busy); end
      key = '0;
      repeat (3) tick();
      checks++; if (seq_addr !== 4'd15) begin errors++; $display("FAIL r15_no_wrap: got %0d expected 15", seq_addr); end
   endtask

   // ---------------- sequencing and report ----------------
   initial begin
      R = 1'b0; start = 1'b0; key = '0; round = '0;
      for (int i = 0; i < 16; i++) seq_mem[i] = '0;
      test_reset();
      test_round_ok();
      test_wrong_press();
      test_multihot_and_hold();
      test_busy_start_and_reset();
      test_start_with_key();
      test_timeout();
      test_round15();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
